fpga_device: RTL and testbench
==============================

# fpga_device

Top-level FPGA demo device: a single-digit decimal counter shown on a seven-segment display. Two slide switches control counting direction and pause. The block sits directly on the board pins: two switches in, seven segment drives out. It is the unit exercised on hardware and in the board-level bench.

## Interface
- `TICK`, default 4: clock cycles per counter step (prescaler period); legal range 1..2^16.
- `clock`, input, 1: system clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset. Low clears all state immediately; release is sampled on the rising edge of `clock`.
- `io_sw0`, input, 1: direction switch, asynchronous to `clock`. 1 = count up, 0 = count down.
- `io_sw1`, input, 1: pause switch, asynchronous to `clock`. 1 = freeze counter and prescaler, 0 = run.
- `io_display`, output, 7: segment drive `{g,f,e,d,c,b,a}`. Bit 0 is segment a. Active-high: 1 = segment lit.

## Operation
- **Switch synchronizers.** Each switch passes through a 2-flop synchronizer. Both flops reset to 0. Internal `dir` and `pause` are the second-stage outputs.
- **Prescaler.**
  - `tick_cnt` has width ceil(log2(TICK)), minimum 1.
  - When `pause`=0: counts 0..TICK-1 and wraps to 0.
  - When `pause`=1: holds its value.
  - `step` is asserted when `pause`=0 and `tick_cnt`==TICK-1.
  - With TICK=1, `step` is asserted every unpaused cycle.
- **Digit register.** `digit` is 4 bits, range 0..9. On `step`:
  - `dir`=1: `digit` = 9 ? 0 : `digit`+1.
  - `dir`=0: `digit` = 0 ? 9 : `digit`-1.
  - Values 10..15 are unreachable. If ever present, the next step loads 0.
- **Decoder.** Combinational from `digit`, driving `io_display`:
  - 0 → 0111111, 1 → 0000110, 2 → 1011011, 3 → 1001111, 4 → 1100110
  - 5 → 1101101, 6 → 1111101, 7 → 0000111, 8 → 1111111, 9 → 1101111
  - 10..15 → 1000000 (dash)
- **Simultaneous events.**
  - A direction change takes effect at the next step after `dir` updates; it never causes an extra step.
  - Pause asserted in the same cycle that `step` would fire suppresses that step.

## Timing
- **Reset values.**
  - `digit`=0 and `io_display`=0111111.
  - `tick_cnt`=0, `dir`=0, `pause`=0.
- **Reset mid-count.** Asserting `reset` low at any time forces the reset values asynchronously, with no wait for a clock edge.
- **Switch latency.** 2 rising edges from a switch change to the internal `dir`/`pause` change.
- **First step after release.** Occurs on the TICK-th rising edge after reset is released, provided `pause` stays 0. With the default TICK=4, the synchronized direction is valid before that first step.
- **Display latency.** `io_display` changes combinationally from the `digit` register, i.e. on the same edge that updates `digit`.
- **Resume.** Counting resumes from the held `tick_cnt`. The pause interval is not counted toward the step period.

## Test plan
- **Reset.** Hold `reset`=0 for 3 cycles with `io_sw0`=1 → `io_display`=0111111 throughout; toggling the switches has no effect.
- **Count up with wrap.** TICK=4, `io_sw0`=1, `io_sw1`=0, release reset →
  - `io_display` = 0000110 after edge 4, 1011011 after edge 8.
  - After edge 40 the digit returns to 0 (0111111).
- **Count down with wrap.** From `digit`=2, drive `io_sw0`=0 → display sequence 2, 1, 0, 9 (1101111), 8; steps remain exactly 4 cycles apart.
- **Pause.** `io_sw1`=1 mid-period → `digit` and `tick_cnt` frozen for 20 cycles. Release `io_sw1` → the next step occurs after the remaining period plus 2 synchronizer cycles.
- **Asynchronous reset mid-count.** Pulse `reset` low between clock edges at `digit`=7 → `io_display` becomes 0111111 before the next rising edge. Counting restarts with the first step TICK edges after release.
- **TICK=1.** Build with TICK=1, `io_sw0`=1 → `digit` increments every cycle once the synchronizers settle, wrapping 9→0.

Source files
------------

// File: rtl/fpga_device.sv
// Single-digit decimal up/down counter that drives a seven-segment display.
// Latency: switches take 2 clocks to reach the core; a step occurs every TICK unpaused clocks; the display follows the digit combinationally.
// Backpressure: none. The pause switch freezes both the prescaler and the digit.
//
// Ports:
//   clock      - system clock; all state changes on the rising edge
//   reset      - asynchronous active-low reset
//   io_sw0     - direction switch, asynchronous (1 = up, 0 = down)
//   io_sw1     - pause switch, asynchronous (1 = freeze)
//   io_display - segments {g,f,e,d,c,b,a}, active-high
module fpga_device #(
    parameter int TICK = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_sw0,
    input  logic       io_sw1,
    output logic [6:0] io_display
);

    // With TICK=1 the counter is a single bit pinned at 0, so step fires on
    // every unpaused cycle.
    localparam int            CW       = (TICK > 1) ? $clog2(TICK) : 1;
    localparam logic [CW-1:0] TICK_MAX = CW'(TICK - 1);

    logic          dir_meta;
    logic          dir;
    logic          pause_meta;
    logic          pause;
    logic [CW-1:0] tick_cnt;
    logic          step;
    logic [3:0]    digit;
    logic [3:0]    digit_nxt;

    // Two-flop synchronizers for the asynchronous switches.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dir_meta   <= 1'b0;
            dir        <= 1'b0;
            pause_meta <= 1'b0;
            pause      <= 1'b0;
        end else begin
            dir_meta   <= io_sw0;
            dir        <= dir_meta;
            pause_meta <= io_sw1;
            pause      <= pause_meta;
        end
    end

    // The prescaler holds while paused, so a resume continues the
    // interrupted period instead of restarting it.
    assign step = !pause && (tick_cnt == TICK_MAX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (!pause) begin
            if (tick_cnt == TICK_MAX) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

    // Next digit on a step. Out-of-range values (10..15) are unreachable,
    // but if present they recover to 0 in either direction.
    always_comb begin
        digit_nxt = 4'd0;
        if (digit > 4'd9) begin
            digit_nxt = 4'd0;
        end else if (dir) begin
            digit_nxt = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
        end else begin
            digit_nxt = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            digit <= 4'd0;
        end else if (step) begin
            digit <= digit_nxt;
        end
    end

    // Seven-segment decoder, bit 0 = segment a.
    always_comb begin
        io_display = 7'b1000000;
        case (digit)
            4'd0:    io_display = 7'b0111111;
            4'd1:    io_display = 7'b0000110;
            4'd2:    io_display = 7'b1011011;
            4'd3:    io_display = 7'b1001111;
            4'd4:    io_display = 7'b1100110;
            4'd5:    io_display = 7'b1101101;
            4'd6:    io_display = 7'b1111101;
            4'd7:    io_display = 7'b0000111;
            4'd8:    io_display = 7'b1111111;
            4'd9:    io_display = 7'b1101111;
            default: io_display = 7'b1000000;
        endcase
    end

endmodule

// File: tb/tb_fpga_device.sv
module tb_fpga_device;

    logic       clock;
    logic       reset;
    logic       io_sw0;
    logic       io_sw1;
    logic [6:0] disp4;
    logic [6:0] disp1;

    int tests;
    int fails;

    fpga_device #(.TICK(4)) dut4 (
        .clock(clock), .reset(reset), .io_sw0(io_sw0), .io_sw1(io_sw1), .io_display(disp4)
    );

    fpga_device #(.TICK(1)) dut1 (
        .clock(clock), .reset(reset), .io_sw0(io_sw0), .io_sw1(io_sw1), .io_display(disp1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Segment table for a decimal digit.
    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b1000000;
        endcase
    endfunction

    // Model: switches seen two edges late (history queues), a phase that
    // advances modulo the period when not paused, and a digit that moves
    // modulo 10 whenever the phase completes a period.
    int ticks [2] = '{4, 1};
    int m_digit [2];
    int m_phase [2];
    bit dir_hist[$];
    bit pause_hist[$];

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_digit    = '{0, 0};
            m_phase    = '{0, 0};
            dir_hist   = '{1'b0, 1'b0};
            pause_hist = '{1'b0, 1'b0};
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!pause_hist[0]) begin
                    m_phase[k] = m_phase[k] + 1;
                    if (m_phase[k] == ticks[k]) begin
                        m_phase[k] = 0;
                        m_digit[k] = dir_hist[0] ? (m_digit[k] + 1) % 10
                                                 : (m_digit[k] + 9) % 10;
                    end
                end
            end
            void'(dir_hist.pop_front());
            dir_hist.push_back(io_sw0);
            void'(pause_hist.pop_front());
            pause_hist.push_back(io_sw1);
        end
    end

    // Continuous compare against the model on every falling edge.
    always @(negedge clock) begin
        tests++;
        if (disp4 !== seg(m_digit[0])) begin
            fails++;
            $display("FAIL model_tick4 t=%0t got=%b exp=%b", $time, disp4, seg(m_digit[0]));
        end
        tests++;
        if (disp1 !== seg(m_digit[1])) begin
            fails++;
            $display("FAIL model_tick1 t=%0t got=%b exp=%b", $time, disp1, seg(m_digit[1]));
        end
    end

    task automatic check_lit(input string name, input logic [6:0] got, input logic [6:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    // Advance n rising edges, then settle on the following falling edge.
    task automatic edges(input int n);
        repeat (n) @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        reset  = 1'b0;
        io_sw0 = 1'b1;
        io_sw1 = 1'b0;

        // Held in reset while switches toggle.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            io_sw0 = i[0];
            io_sw1 = ~i[0];
            check_lit("reset_hold", disp4, 7'b0111111);
        end
        io_sw0 = 1'b1;
        io_sw1 = 1'b0;
        @(negedge clock);
        reset = 1'b1;

        // Count up from release.
        edges(3);
        check_lit("up_edge3", disp4, 7'b0111111);
        edges(1);
        check_lit("up_edge4", disp4, 7'b0000110);
        check_lit("tick1_edge4", disp1, 7'b0111111);
        edges(4);
        check_lit("up_edge8", disp4, 7'b1011011);
        edges(32);
        check_lit("up_wrap_edge40", disp4, 7'b0111111);
        edges(8);
        check_lit("up_edge48", disp4, 7'b1011011);

        // Count down across the 0 -> 9 wrap, steps exactly 4 edges apart.
        io_sw0 = 1'b0;
        edges(3);
        check_lit("down_hold51", disp4, 7'b1011011);
        edges(1);
        check_lit("down_1", disp4, 7'b0000110);
        edges(3);
        check_lit("down_hold55", disp4, 7'b0000110);
        edges(1);
        check_lit("down_0", disp4, 7'b0111111);
        edges(3);
        check_lit("down_hold59", disp4, 7'b0111111);
        edges(1);
        check_lit("down_9", disp4, 7'b1101111);
        edges(4);
        check_lit("down_8", disp4, 7'b1111111);

        // Pause mid-period: phase frozen at 2, digit at 8.
        io_sw1 = 1'b1;
        for (int i = 0; i < 22; i++) begin
            edges(1);
            check_lit("paused", disp4, 7'b1111111);
        end
        io_sw1 = 1'b0;
        edges(3);
        check_lit("resume_hold", disp4, 7'b1111111);
        edges(1);
        check_lit("resume_step", disp4, 7'b0000111);

        // Asynchronous reset pulse between edges while showing 7.
        #2;
        reset = 1'b0;
        #1;
        check_lit("async_reset4", disp4, 7'b0111111);
        check_lit("async_reset1", disp1, 7'b0111111);
        #1;
        reset = 1'b1;
        edges(3);
        check_lit("post_reset_hold", disp4, 7'b0111111);
        edges(1);
        check_lit("post_reset_step", disp4, 7'b1101111);

        // Count up; TICK=1 instance increments every cycle, wrapping 9 -> 0.
        io_sw0 = 1'b1;
        begin
            int guard;
            guard = 0;
            while (m_digit[1] != 9 && guard < 40) begin
                edges(1);
                guard++;
            end
            tests++;
            if (m_digit[1] != 9) begin
                fails++;
                $display("FAIL tick1_reach9 got=%0d exp=9", m_digit[1]);
            end
        end
        check_lit("tick1_at9", disp1, 7'b1101111);
        edges(1);
        check_lit("tick1_wrap0", disp1, 7'b0111111);
        edges(1);
        check_lit("tick1_1", disp1, 7'b0000110);
        edges(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
